// File: rtl/dcache_mem_responder.sv
// Backing-memory responder for the D-cache: serialized line fills and writebacks with programmable latency.
// Optional DCACHE_MEM_STATS_EN adds saturating fill/writeback counters.
module dcache_mem_responder #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int LATENCY    = 3,
  parameter int MEM_WORDS  = 16384
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              rlast,
  output logic              wdone,
  output logic              busy
`ifdef DCACHE_MEM_STATS_EN
  ,
  output logic [31:0]       fill_count,
  output logic [31:0]       wb_count
`endif
);
  localparam int OFF = $clog2(LINE_WORDS);
  localparam int MW  = $clog2(MEM_WORDS);
  localparam int LW  = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [OFF-1:0] LAST = OFF'(LINE_WORDS - 1);

  typedef enum logic [2:0] {IDLE, WAIT, RBURST, WBURST, WDONE} state_t;

  state_t            state, state_d;
  logic [MW-1:0]     base, base_d, idx;
  logic              we_q;
  logic [LW-1:0]     lat_cnt;
  logic [OFF-1:0]    beat;
  logic [31:0]       widx;
  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic              unused_addr;

  // Line-aligned word index of the request; byte/beat offset bits are dropped.
  assign widx        = 32'({req_addr[ADDR_W-1:OFF+2], OFF'(0)});
  assign base_d      = MW'(widx % 32'(MEM_WORDS));
  assign idx         = MW'((32'(base) + 32'(beat)) % 32'(MEM_WORDS));
  assign unused_addr = ^req_addr[OFF+1:0];

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rvalid    = (state == RBURST);
  assign rlast     = rvalid && (beat == LAST);
  assign rdata     = rvalid ? mem[idx] : '0;
  assign wready    = (state == WBURST);
  assign wdone     = (state == WDONE);

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (req_valid)
                 state_d = (LATENCY == 0) ? (req_we ? WBURST : RBURST) : WAIT;
      WAIT:    if (lat_cnt == LW'(1)) state_d = we_q ? WBURST : RBURST;
      RBURST:  if (beat == LAST) state_d = IDLE;
      WBURST:  if (wvalid && beat == LAST) state_d = WDONE;
      WDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      base    <= '0;
      we_q    <= 1'b0;
      lat_cnt <= '0;
      beat    <= '0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: if (req_valid) begin
          base    <= base_d;
          we_q    <= req_we;
          lat_cnt <= LW'(LATENCY);
          beat    <= '0;
        end
        WAIT:    lat_cnt <= lat_cnt - LW'(1);
        RBURST:  beat <= beat + OFF'(1);
        WBURST:  if (wvalid) beat <= beat + OFF'(1);
        default: ;
      endcase
    end
  end

  // Array is deliberately not reset; partial writebacks survive a reset.
  always_ff @(posedge clk) begin
    if (state == WBURST && wvalid) mem[idx] <= wdata;
  end

`ifdef DCACHE_MEM_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_count <= '0;
      wb_count   <= '0;
    end else begin
      if (rlast && fill_count != '1) fill_count <= fill_count + 32'd1;
      if (wdone && wb_count != '1)   wb_count   <= wb_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dcache_mem_responder.sv
// Directed bench: one responder with LATENCY=3 and one with LATENCY=0 sharing the request bus.
module tb_dcache_mem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, wvalid = 1'b0, use0 = 1'b0;
  logic [15:0] req_addr = '0;
  logic [31:0] wdata = '0;
  logic        rv3, rv0;
  logic        a_ready, a_wready, a_rvalid, a_rlast, a_wdone, a_busy;
  logic        b_ready, b_wready, b_rvalid, b_rlast, b_wdone, b_busy;
  logic [31:0] a_rdata, b_rdata;
  logic        m_ready, m_wready, m_rvalid, m_rlast, m_wdone, m_busy;
  logic [31:0] m_rdata;
  int checks = 0, failures = 0;
`ifdef DCACHE_MEM_STATS_EN
  logic [31:0] a_fc, a_wc, b_fc, b_wc;
`endif

  always #5 clk = ~clk;

  assign rv3 = req_valid & ~use0;
  assign rv0 = req_valid & use0;
  assign m_ready  = use0 ? b_ready  : a_ready;
  assign m_wready = use0 ? b_wready : a_wready;
  assign m_rvalid = use0 ? b_rvalid : a_rvalid;
  assign m_rlast  = use0 ? b_rlast  : a_rlast;
  assign m_wdone  = use0 ? b_wdone  : a_wdone;
  assign m_busy   = use0 ? b_busy   : a_busy;
  assign m_rdata  = use0 ? b_rdata  : a_rdata;

  dcache_mem_responder #(.LATENCY(3)) u_d3 (
    .clk(clk), .rst(rst), .req_valid(rv3), .req_ready(a_ready), .req_we(req_we),
    .req_addr(req_addr), .wdata(wdata), .wvalid(wvalid), .wready(a_wready),
    .rdata(a_rdata), .rvalid(a_rvalid), .rlast(a_rlast), .wdone(a_wdone), .busy(a_busy)
`ifdef DCACHE_MEM_STATS_EN
    , .fill_count(a_fc), .wb_count(a_wc)
`endif
  );

  dcache_mem_responder #(.LATENCY(0)) u_d0 (
    .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(b_ready), .req_we(req_we),
    .req_addr(req_addr), .wdata(wdata), .wvalid(wvalid), .wready(b_wready),
    .rdata(b_rdata), .rvalid(b_rvalid), .rlast(b_rlast), .wdone(b_wdone), .busy(b_busy)
`ifdef DCACHE_MEM_STATS_EN
    , .fill_count(b_fc), .wb_count(b_wc)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input string tag, input logic [15:0] addr, input logic [3:0][31:0] exp);
    int lat;
    lat = use0 ? 0 : 3;
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < lat; i++) begin
      check({tag, " wait rvalid"}, 32'(m_rvalid), 32'd0);
      check({tag, " wait ready"}, 32'(m_ready), 32'd0);
      tick();
    end
    for (int b = 0; b < 4; b++) begin
      check($sformatf("%s rvalid%0d", tag, b), 32'(m_rvalid), 32'd1);
      check($sformatf("%s rdata%0d", tag, b), m_rdata, exp[b]);
      check($sformatf("%s rlast%0d", tag, b), 32'(m_rlast), 32'(b == 3));
      tick();
    end
    check({tag, " end ready"}, 32'(m_ready), 32'd1);
    check({tag, " end rvalid"}, 32'(m_rvalid), 32'd0);
  endtask

  // pat: wvalid per WBURST cycle (bit i = cycle i); hold keeps a fill request pending.
  task automatic wback(input string tag, input logic [15:0] addr, input logic [3:0][31:0] d,
                       input logic [7:0] pat, input int len, input bit hold);
    int n, k;
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr;
    tick();
    if (hold) req_we = 1'b0; else req_valid = 1'b0;
    n = 0;
    while (!m_wready && n < 10) begin
      if (hold) check({tag, " held ready"}, 32'(m_ready), 32'd0);
      tick(); n++;
    end
    check({tag, " wready"}, 32'(m_wready), 32'd1);
    if (!m_wready) return;
    k = 0;
    for (int i = 0; i < len; i++) begin
      wvalid = pat[i]; wdata = d[k[1:0]];
      check({tag, " burst ready"}, 32'(m_ready), 32'd0);
      tick();
      if (pat[i]) k++;
      if (k < 4) check($sformatf("%s early wdone%0d", tag, i), 32'(m_wdone), 32'd0);
    end
    wvalid = 1'b0;
    check({tag, " wdone"}, 32'(m_wdone), 32'd1);
    tick();
    check({tag, " wdone drop"}, 32'(m_wdone), 32'd0);
    check({tag, " busy after"}, 32'(m_busy), 32'd0);
  endtask

  initial begin
    #3;
    check("rst ready", 32'(a_ready), 32'd1);
    check("rst busy", 32'(a_busy), 32'd0);
    check("rst rvalid", 32'(a_rvalid), 32'd0);
    check("rst rlast", 32'(a_rlast), 32'd0);
    check("rst rdata", a_rdata, 32'd0);
    check("rst wready", 32'(a_wready), 32'd0);
    check("rst wdone", 32'(a_wdone), 32'd0);
    check("rst0 ready", 32'(b_ready), 32'd1);
    tick(); rst = 1'b1; tick();

    wback("pre", 16'h9000, {32'd44, 32'd33, 32'd22, 32'd11}, 8'h0F, 4, 1'b0);
    fill("fill9000", 16'h9000, {32'd44, 32'd33, 32'd22, 32'd11});

    wback("wbA", 16'h9010, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 8'h0F, 4, 1'b1);
    check("memA0", u_d3.mem[14'h2404], 32'hA0);
    check("memA3", u_d3.mem[14'h2407], 32'hA3);
    fill("fill9010", 16'h9010, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

    // wvalid 1,0,0,1,1,0,1
    wback("wbstall", 16'h9020, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 8'b0101_1001, 7, 1'b0);
    check("memB0", u_d3.mem[14'h2408], 32'hB0);
    check("memB1", u_d3.mem[14'h2409], 32'hB1);
    check("memB2", u_d3.mem[14'h240A], 32'hB2);
    check("memB3", u_d3.mem[14'h240B], 32'hB3);

    // Reset mid-writeback after two beats.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h9020;
    tick(); req_valid = 1'b0;
    for (int i = 0; i < 10 && !a_wready; i++) tick();
    check("rstwb wready", 32'(a_wready), 32'd1);
    wvalid = 1'b1; wdata = 32'hD0; tick();
    wdata = 32'hD1; tick();
    wvalid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("async wready", 32'(a_wready), 32'd0);
    check("async ready", 32'(a_ready), 32'd1);
    check("async busy", 32'(a_busy), 32'd0);
    tick(); rst = 1'b1;
    check("keep D0", u_d3.mem[14'h2408], 32'hD0);
    check("keep D1", u_d3.mem[14'h2409], 32'hD1);
    check("keep B2", u_d3.mem[14'h240A], 32'hB2);
    check("keep B3", u_d3.mem[14'h240B], 32'hB3);
    fill("fillrst", 16'h9020, {32'hB3, 32'hB2, 32'hD1, 32'hD0});
`ifdef DCACHE_MEM_STATS_EN
    check("d3 fill_count", a_fc, 32'd1);
    check("d3 wb_count", a_wc, 32'd0);
`endif

    use0 = 1'b1;
    wback("wb0", 16'hFFF0, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 8'h0F, 4, 1'b0);
    check("memE0", u_d0.mem[14'h3FFC], 32'hE0);
    check("memE3", u_d0.mem[14'h3FFF], 32'hE3);
    fill("fill0", 16'hFFF0, {32'hE3, 32'hE2, 32'hE1, 32'hE0});
`ifdef DCACHE_MEM_STATS_EN
    check("d0 fill_count", b_fc, 32'd1);
    check("d0 wb_count", b_wc, 32'd1);
    $display("stats d3 fills=%0d wbs=%0d d0 fills=%0d wbs=%0d", a_fc, a_wc, b_fc, b_wc);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dcache_mem_responder.md
Name: dcache_mem_responder

Overview:
- Backing-memory responder on the memory side of the write-back D-cache.
- Accepts line fill (read) and dirty-line writeback (write) bursts from the cache miss handler, inserts a programmable access latency, and streams or absorbs LINE_WORDS words per request.
- Owns the data-memory word array that the CPU-level bench preloads and checks at the answer region (0x9000 onward).

Parameters:
- ADDR_W, 16, byte-address width of req_addr.
- DATA_W, 32, word width.
- LINE_WORDS, 4, words per cache line; power of two, >= 2.
- LATENCY, 3, idle cycles between request acceptance and first data beat; 0 allowed.
- MEM_WORDS, 16384, depth of internal word array `mem`, index = word address.

Ports:
- clk, in, 1, clock; all logic on rising edge.
- rst, in, 1, asynchronous active-low reset (0 = reset).
- req_valid, in, 1, cache presents a line request.
- req_ready, out, 1, responder can accept a request.
- req_we, in, 1, 1 = writeback, 0 = line fill.
- req_addr, in, ADDR_W, byte address; low log2(LINE_WORDS)+2 bits ignored (line-aligned).
- wdata, in, DATA_W, writeback beat data.
- wvalid, in, 1, wdata valid this cycle.
- wready, out, 1, responder absorbing writeback beats.
- rdata, out, DATA_W, fill beat data.
- rvalid, out, 1, rdata valid.
- rlast, out, 1, final fill beat.
- wdone, out, 1, one-cycle pulse when the writeback is committed.
- busy, out, 1, high in any state other than IDLE.

Behaviour:
- Reset values (async assert): state IDLE, req_ready=1, busy=0, rvalid=0, rlast=0, rdata=0, wready=0, wdone=0, beat and latency counters 0. `mem` contents are not reset.
- States: IDLE, WAIT, RBURST, WBURST, WDONE.
- IDLE:
  - A request is accepted when req_valid && req_ready.
  - Latch base = line word index mod MEM_WORDS, and latch we.
  - Load latency counter with LATENCY.
  - Next state: WAIT, or RBURST/WBURST directly when LATENCY=0.
  - req_ready is 0 in every non-IDLE state; req_valid is ignored there.
- WAIT: counter decrements each cycle; at 1, next state RBURST if !we, else WBURST.
- RBURST:
  - Exactly LINE_WORDS consecutive cycles with rvalid=1 and rdata=mem[base+beat], beat = 0..LINE_WORDS-1.
  - rlast=1 on beat LINE_WORDS-1. No backpressure.
  - Next state IDLE; req_ready=1 on the cycle after rlast.
- WBURST:
  - wready=1 throughout.
  - On each cycle with wvalid=1, mem[base+beat] <= wdata and beat++.
  - A wvalid=0 cycle stalls the burst with no write.
  - After the write of beat LINE_WORDS-1, next state WDONE.
- WDONE: wdone=1 for one cycle, then IDLE.
- A written word is visible to any later fill; read-after-write ordering is strict because requests are serialized.
- Addressing:
  - Beat index wraps within LINE_WORDS; a line never crosses a line boundary.
  - Line word index wraps modulo MEM_WORDS.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. Beats already written in a partial writeback stay in `mem`.
- Fill latency: first rvalid occurs LATENCY+1 cycles after the acceptance edge, and the last beat LATENCY+LINE_WORDS cycles after it.

Optional Feature:
- Macro DCACHE_MEM_STATS_EN.
- When defined:
  - Adds outputs fill_count (32, out) and wb_count (32, out), both reset to 0.
  - fill_count increments on each rlast; wb_count increments on each wdone.
  - Both saturate at 0xFFFFFFFF.
  - Bench prints them next to the read/read-hit/write/write-hit summary.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Fill, LATENCY=3: preload mem[0x2400..0x2403]=11,22,33,44; req_addr=0x9000, req_we=0 -> rvalid on cycles 4-7 after acceptance, rdata 11,22,33,44, rlast only with 44, req_ready=1 on cycle 8.
- Writeback, no stalls: req_addr=0x9010, req_we=1, wvalid=1 on 4 cycles with A0..A3 -> mem[0x2404..0x2407]=A0..A3, then one wdone pulse, busy=0 the cycle after.
- Writeback with stalls: wvalid pattern 1,0,0,1,1,0,1 -> exactly 4 writes at consecutive word indices, wdone only after the 4th beat.
- Write then fill of the same line (0x9010) -> rdata returns A0..A3; a req_valid held high during the writeback is not accepted until IDLE.
- Reset mid-writeback: drop rst low after 2 beats -> outputs at reset values asynchronously, mem keeps 2 new words and 2 old words, next request is accepted normally.
- LATENCY=0 and wrap: req_addr=0xFFF0 with MEM_WORDS=16384 -> first rvalid 1 cycle after acceptance, reading word indices (0x3FFC..0x3FFF) mod 16384; with DCACHE_MEM_STATS_EN, fill_count=1.
